axi_dma_perf_reader: RTL and testbench
======================================

// Module: axi_dma_perf_reader
// PURPOSE
//  Software-side reader for the DMA performance bus (axi_dma_pkg::dma_perf_t).
//  - Takes an atomic snapshot of all counters on command, optionally with a read-and-clear.
//  - Exposes the snapshot as 32-bit words over a simple valid/ready register request/response port.
//  - Sits between the perf-counter block and the cluster peripheral interconnect.
// PARAMETERS
//  perf_t      axi_dma_pkg::dma_perf_t  packed perf bus type; NumWords = ceil($bits(perf_t)/32)
//  ADDR_WIDTH  8                        byte-address width of register port; must hold (2+NumWords)*4
// PORTS
//  clk_i            in   1           clock
//  rst_ni           in   1           async active-low reset
//  dma_perf_i       in   perf_t      live counter bus
//  reg_req_valid_i  in   1           request valid
//  reg_req_ready_o  out  1           request ready
//  reg_req_addr_i   in   ADDR_WIDTH  byte address
//  reg_req_write_i  in   1           1=write, 0=read
//  reg_req_wdata_i  in   32          write data
//  reg_rsp_valid_o  out  1           response valid
//  reg_rsp_ready_i  in   1           response ready
//  reg_rsp_rdata_o  out  32          read data (0 on writes/errors)
//  reg_rsp_error_o  out  1           response error
//  perf_clear_o     out  1           one-cycle pulse: clear the perf counters
//  snap_valid_o     out  1           snapshot register holds captured data
// BEHAVIOUR
//  Address map (word index = addr[ADDR_WIDTH-1:2]):
//  - 0 CTRL. W: bit0 SNAP, bit1 CLEAR. R: bit0 snap_valid, [15:8] NumWords, others 0.
//  - 1 SEQ. RO, 32-bit snapshot count.
//  - 2+i DATA[i]. RO, bits [32i+31:32i] of zero-padded snapshot.
//  Reset values: all outputs, snapshot, SEQ and state are 0.
//  FSM: IDLE, RESP.
//  - reg_req_ready_o = (state==IDLE).
//  - Accept (valid&&ready) at edge N moves to RESP; rsp_valid_o is high from N+1.
//  - RESP holds rdata/error stable until reg_rsp_ready_i, then returns to IDLE.
//  - One outstanding request; max throughput is 1 request per 2 cycles.
//  CTRL write with SNAP=1:
//  - snap_q <= dma_perf_i at the accept edge; snap_valid <= 1; SEQ <= SEQ+1 (wraps 0xFFFFFFFF->0).
//  CTRL write with CLEAR=1:
//  - perf_clear_o is high exactly in cycle N+1, independent of rsp_ready.
//  SNAP and CLEAR together:
//  - The snapshot holds the pre-clear values, which makes this an atomic read-and-clear.
//  - CLEAR alone leaves snap_q, snap_valid and SEQ untouched.
//  Read addressing:
//  - Reads are combinational from the registers at the accept edge and captured into the rsp register.
//  - DATA reads while snap_valid=0 return 0, no error.
//  Error cases (rsp_error_o=1, rdata 0, no side effects):
//  - addr[1:0] != 0.
//  - Word index >= 2+NumWords.
//  - Write to SEQ or DATA.
//  Other rules:
//  - CTRL write bits [31:2] are ignored.
//  - Request inputs are ignored outside IDLE; the requester must hold them until ready.
//  - Reset mid-transaction drops the pending response, clear pulse and snapshot (all to 0).
// TESTING
//  1 Reset, read addr 0x0 -> rdata=NumWords<<8, error=0; read 0x8 -> 0.
//  2 Drive counters=K, write CTRL=0x1 -> SEQ=1, snap_valid=1.
//    Change counters, read DATA[0..] -> words of K.
//  3 Write CTRL=0x3 at edge N -> perf_clear_o high only at N+1; snapshot = pre-clear values; SEQ increments.
//  4 Hold reg_rsp_ready_i=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0; release -> ready at next cycle.
//  5 Read addr 0x2, read index 2+NumWords, write 0x4 -> error=1 each, no state change.
//  6 Preload SEQ=0xFFFFFFFF, SNAP -> SEQ=0.
//    Assert rst_ni low during RESP -> rsp_valid=0, snap_valid=0 immediately.

Source files
------------

// File: rtl/axi_dma_perf_reader.sv
// -----------------------------------------------------------------------------
// axi_dma_perf_reader
//
// Software-side reader for the DMA performance counter bus. A CTRL write can
// take an atomic snapshot of every counter, request a one-cycle clear of the
// live counters, or both at once (read-and-clear). The snapshot is then read
// back as 32-bit words over a simple valid/ready request/response port.
//
// Register map (word index = addr[ADDR_WIDTH-1:2]):
//   0       CTRL  W: bit0 SNAP, bit1 CLEAR
//                 R: bit0 snap_valid, [15:8] NumWords
//   1       SEQ   RO: number of snapshots taken (wraps)
//   2+i     DATA  RO: word i of the zero-padded snapshot
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   dma_perf_i       live counter bus
//   reg_req_*        request channel (valid/ready, addr, write, wdata)
//   reg_rsp_*        response channel (valid/ready, rdata, error)
//   perf_clear_o     one-cycle pulse asking the counter block to clear
//   snap_valid_o     snapshot register holds captured data
// -----------------------------------------------------------------------------
package axi_dma_pkg;

  typedef struct packed {
    logic [31:0] ar_count;
    logic [31:0] aw_count;
    logic [31:0] r_beats;
    logic [31:0] w_beats;
    logic [31:0] stall_cycles;
    logic [15:0] error_count;
  } dma_perf_t;

endpackage

module axi_dma_perf_reader #(
  parameter type         perf_t     = axi_dma_pkg::dma_perf_t,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  perf_t                 dma_perf_i,
  input  logic                  reg_req_valid_i,
  output logic                  reg_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] reg_req_addr_i,
  input  logic                  reg_req_write_i,
  input  logic [31:0]           reg_req_wdata_i,
  output logic                  reg_rsp_valid_o,
  input  logic                  reg_rsp_ready_i,
  output logic [31:0]           reg_rsp_rdata_o,
  output logic                  reg_rsp_error_o,
  output logic                  perf_clear_o,
  output logic                  snap_valid_o
);

  localparam int unsigned PerfBits = $bits(perf_t);
  localparam int unsigned NumWords = (PerfBits + 31) / 32;
  localparam int unsigned NumRegs  = 2 + NumWords;
  localparam int unsigned IdxWidth = ADDR_WIDTH - 2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e      state_reg;
  perf_t       snap_reg;
  logic        snap_valid_reg;
  logic [31:0] seq_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_error_reg;
  logic        clear_reg;

  // Snapshot split into 32-bit words, upper word zero-padded.
  logic [PerfBits-1:0]     snap_bits;
  logic [NumWords*32-1:0]  snap_padded;
  logic [31:0]             snap_words [NumWords];

  assign snap_bits = snap_reg;

  always_comb begin
    snap_padded                 = '0;
    snap_padded[PerfBits-1:0]   = snap_bits;
  end

  generate
    for (genvar gi = 0; gi < NumWords; gi++) begin : g_words
      assign snap_words[gi] = snap_padded[32*gi +: 32];
    end
  endgenerate

  // Request decode, evaluated against the registers as they stand at the
  // accept edge. Errors suppress every side effect and force rdata to 0.
  logic [IdxWidth-1:0] word_idx;
  logic [31:0]         dec_rdata;
  logic                dec_error;
  logic                do_snap;
  logic                do_clear;

  assign word_idx = reg_req_addr_i[ADDR_WIDTH-1:2];

  always_comb begin
    dec_rdata = '0;
    dec_error = 1'b0;
    do_snap   = 1'b0;
    do_clear  = 1'b0;
    if (reg_req_addr_i[1:0] != 2'b00 || 32'(word_idx) >= NumRegs) begin
      dec_error = 1'b1;
    end else if (reg_req_write_i) begin
      if (word_idx != '0) begin
        dec_error = 1'b1;
      end else begin
        do_snap  = reg_req_wdata_i[0];
        do_clear = reg_req_wdata_i[1];
      end
    end else if (word_idx == '0) begin
      dec_rdata = {16'h0000, 8'(NumWords), 7'h00, snap_valid_reg};
    end else if (32'(word_idx) == 32'd1) begin
      dec_rdata = seq_reg;
    end else if (snap_valid_reg) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        if (32'(word_idx) == i + 2) begin
          dec_rdata = snap_words[i];
        end
      end
    end
  end

  // CTRL write bits [31:2] have no function.
  logic unused_wdata;
  assign unused_wdata = ^reg_req_wdata_i[31:2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      snap_reg       <= '0;
      snap_valid_reg <= 1'b0;
      seq_reg        <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= '0;
      rsp_error_reg  <= 1'b0;
      clear_reg      <= 1'b0;
    end else begin
      // Clear pulse lasts exactly the cycle after the accepting edge.
      clear_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (reg_req_valid_i) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= dec_rdata;
            rsp_error_reg <= dec_error;
            clear_reg     <= do_clear;
            // Snapshot samples the bus at the same edge the clear is issued
            // from, so SNAP|CLEAR captures the pre-clear values.
            if (do_snap) begin
              snap_reg       <= dma_perf_i;
              snap_valid_reg <= 1'b1;
              seq_reg        <= seq_reg + 32'd1;
            end
          end
        end
        RESP: begin
          if (reg_rsp_ready_i) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign reg_req_ready_o = (state_reg == IDLE);
  assign reg_rsp_valid_o = rsp_valid_reg;
  assign reg_rsp_rdata_o = rsp_rdata_reg;
  assign reg_rsp_error_o = rsp_error_reg;
  assign perf_clear_o    = clear_reg;
  assign snap_valid_o    = snap_valid_reg;

endmodule

// File: tb/tb_axi_dma_perf_reader.sv
// -----------------------------------------------------------------------------
// tb_axi_dma_perf_reader
//
// Scoreboard bench: the stimulus process computes each expected response from a
// register-map model at the moment the request is accepted and queues it; an
// independent monitor compares whatever the DUT presents on the response port
// (and the clear pulse) against that queue.
// -----------------------------------------------------------------------------
module tb_axi_dma_perf_reader;
  import axi_dma_pkg::*;

  localparam int AW        = 8;
  localparam int PERF_BITS = $bits(dma_perf_t);
  localparam int NW        = (PERF_BITS + 31) / 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  dma_perf_t       perf;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            req_write;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_error;
  logic            perf_clear;
  logic            snap_valid;

  always #5 clk = ~clk;

  axi_dma_perf_reader #(.ADDR_WIDTH(AW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .dma_perf_i      (perf),
    .reg_req_valid_i (req_valid),
    .reg_req_ready_o (req_ready),
    .reg_req_addr_i  (req_addr),
    .reg_req_write_i (req_write),
    .reg_req_wdata_i (req_wdata),
    .reg_rsp_valid_o (rsp_valid),
    .reg_rsp_ready_i (rsp_ready),
    .reg_rsp_rdata_o (rsp_rdata),
    .reg_rsp_error_o (rsp_error),
    .perf_clear_o    (perf_clear),
    .snap_valid_o    (snap_valid)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    logic        snap_valid;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Register-map model.
  logic [NW*32-1:0] m_snap;
  logic             m_valid;
  logic [31:0]      m_seq;
  logic             clear_due = 1'b0;
  int               rdy_mode  = 0;   // 0 random, 1 hold low, 2 hold high

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endfunction

  function automatic dma_perf_t rand_perf();
    dma_perf_t p;
    p = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
    return p;
  endfunction

  function automatic void model_reset();
    m_snap    = '0;
    m_valid   = 1'b0;
    m_seq     = '0;
    clear_due = 1'b0;
  endfunction

  // Expected response plus model side effects for a request accepted now.
  function automatic exp_t model_req(logic [AW-1:0] addr, logic wr, logic [31:0] wdata,
                                     string name);
    exp_t e;
    int   idx;
    idx          = int'(addr) / 4;
    e.rdata      = '0;
    e.error      = 1'b0;
    e.name       = name;
    if ((int'(addr) % 4) != 0 || idx >= 2 + NW || (wr && idx != 0)) begin
      e.error = 1'b1;
    end else if (wr) begin
      if (wdata[0]) begin
        m_snap                 = '0;
        m_snap[PERF_BITS-1:0]  = perf;
        m_valid                = 1'b1;
        m_seq                  = m_seq + 32'd1;
      end
    end else if (idx == 0) begin
      e.rdata = 32'(NW * 256) | 32'(m_valid);
    end else if (idx == 1) begin
      e.rdata = m_seq;
    end else if (m_valid) begin
      e.rdata = m_snap[(idx - 2) * 32 +: 32];
    end
    e.snap_valid = m_valid;
    return e;
  endfunction

  task automatic do_req(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                        input string name);
    exp_t e;
    bit   accepted;
    accepted = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wdata;
    for (int c = 0; c < 200; c++) begin
      if (req_ready) begin
        e = model_req(addr, wr, wdata, name);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (wr && !e.error && wdata[1]) clear_due = 1'b1;
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout %s: req_ready 0, expected 1", name);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  // Response-ready driver, updated away from both clock edges.
  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1)      rsp_ready = 1'b0;
    else if (rdy_mode == 2) rsp_ready = 1'b1;
    else                    rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: clear pulse and response port against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear_due || perf_clear) begin
        check("perf_clear", 32'(perf_clear), 32'(clear_due));
        clear_due = 1'b0;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid 1 with rdata 0x%08h, expected no response",
                   rsp_rdata);
        end else if (rsp_ready) begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
          check({mon_e.name, "_error"}, 32'(rsp_error), 32'(mon_e.error));
          check({mon_e.name, "_snap_valid"}, 32'(snap_valid), 32'(mon_e.snap_valid));
          $display("txn %-14s rdata=0x%08h error=%0d snap_valid=%0d",
                   mon_e.name, rsp_rdata, rsp_error, snap_valid);
        end else begin
          mon_e = exp_q[0];
          check({mon_e.name, "_hold_rdata"}, rsp_rdata, mon_e.rdata);
          check({mon_e.name, "_hold_error"}, 32'(rsp_error), 32'(mon_e.error));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic          w;
    logic [31:0]   d;
    int            r;

    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    perf      = rand_perf();
    model_reset();

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_snap_valid", 32'(snap_valid), 32'd0);
    check("rst_perf_clear", 32'(perf_clear), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    do_req(8'h00, 1'b0, 32'h0, "rd_ctrl_rst");
    do_req(8'h08, 1'b0, 32'h0, "rd_data0_rst");
    do_req(8'h04, 1'b0, 32'h0, "rd_seq_rst");

    // 2: snapshot, then change the live counters and read the snapshot back
    perf = rand_perf();
    do_req(8'h00, 1'b1, 32'h1, "wr_snap");
    perf = rand_perf();
    do_req(8'h04, 1'b0, 32'h0, "rd_seq");
    for (int i = 0; i < NW; i++) do_req(AW'((2 + i) * 4), 1'b0, 32'h0, $sformatf("rd_data%0d", i));
    do_req(8'h00, 1'b0, 32'h0, "rd_ctrl");

    // 3: read-and-clear
    perf = rand_perf();
    do_req(8'h00, 1'b1, 32'h3, "wr_snap_clr");
    perf = rand_perf();
    for (int i = 0; i < NW; i++) do_req(AW'((2 + i) * 4), 1'b0, 32'h0, $sformatf("rd_sc_data%0d", i));
    do_req(8'h04, 1'b0, 32'h0, "rd_seq_sc");
    drain();

    // 4: response back-pressure
    rdy_mode = 1;
    do_req(8'h04, 1'b0, 32'h0, "rd_seq_stall");
    repeat (5) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #3;
    rsp_ready = 1'b1;
    rdy_mode  = 2;
    @(posedge clk);
    @(negedge clk);
    check("release_req_ready", 32'(req_ready), 32'd1);
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);
    rdy_mode = 0;

    // 5: error cases and CLEAR alone
    do_req(8'h02, 1'b0, 32'h0, "rd_misalign");
    do_req(AW'((2 + NW) * 4), 1'b0, 32'h0, "rd_oob");
    do_req(8'h04, 1'b1, 32'h1, "wr_seq");
    do_req(8'h08, 1'b1, 32'h3, "wr_data0");
    do_req(8'h01, 1'b1, 32'h3, "wr_misalign");
    perf = rand_perf();
    do_req(8'h00, 1'b1, 32'hFFFF_FFFE, "wr_clr_only");
    do_req(8'h04, 1'b0, 32'h0, "rd_seq_err");
    do_req(8'h08, 1'b0, 32'h0, "rd_data0_err");

    // Randomized mix of reads, CTRL writes and illegal accesses
    for (int n = 0; n < 80; n++) begin
      perf = rand_perf();
      r = $urandom_range(0, 9);
      w = ($urandom_range(0, 2) == 0);
      d = $urandom();
      if (r < 8) a = AW'($urandom_range(0, NW + 1) * 4);
      else if (r == 8) a = AW'($urandom_range(0, NW + 1) * 4 + $urandom_range(1, 3));
      else a = AW'($urandom_range(2 + NW, 63) * 4);
      if (w && $urandom_range(0, 9) < 7) a = '0;
      do_req(a, w, d, w ? "rnd_wr" : "rnd_rd");
    end
    drain();

    // 6: SEQ wrap from a preloaded value
    @(negedge clk);
    force dut.seq_reg = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.seq_reg;
    m_seq = 32'hFFFF_FFFF;
    do_req(8'h04, 1'b0, 32'h0, "rd_seq_pre");
    perf = rand_perf();
    do_req(8'h00, 1'b1, 32'h1, "wr_snap_wrap");
    do_req(8'h04, 1'b0, 32'h0, "rd_seq_wrap");
    drain();

    // Reset while a response is pending
    rdy_mode = 1;
    do_req(8'h00, 1'b0, 32'h0, "rd_ctrl_pend");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_snap_valid", 32'(snap_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    rdy_mode = 0;
    do_req(8'h00, 1'b0, 32'h0, "rd_ctrl_arst");
    do_req(8'h04, 1'b0, 32'h0, "rd_seq_arst");
    do_req(8'h08, 1'b0, 32'h0, "rd_data0_arst");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
